matrix_row_loader: RTL and testbench
====================================

MATRIX_ROW_LOADER -- requirements
Module: matrix_row_loader

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 16, width in bits of one matrix element.
REQ-002 The block SHALL have parameter COLUMN_SIZE, default 16, elements per row.
REQ-003 The block SHALL have parameter ROW_SIZE, default 16, rows per matrix load.
REQ-004 clock  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin loading one matrix.
REQ-007 in_valid  input  1  in_data holds a valid element.
REQ-008 in_data  input  DATA_SIZE  element stream, row-major.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 row_out  output  1024  packed row, drives the matrix core's in_row.
REQ-011 enable  output  1  one-cycle pulse: row_out holds a complete new row.
REQ-012 dendFlag  output  1  high with the enable pulse of the last row of a matrix.
REQ-013 busy  output  1  high from accepted start until done.
REQ-014 done  output  1  one-cycle pulse after the last row is emitted.

Function
REQ-015 The FSM SHALL have states IDLE, FILL, EMIT, FINISH.
REQ-016 IDLE: in_ready=0, busy=0; start=1 -> FILL, clears element counter and row counter.
REQ-017 start SHALL be ignored in any state other than IDLE.
REQ-018 FILL: in_ready=1, busy=1; transfer occurs only when in_valid=1 and in_ready=1.
REQ-019 Transfer k (k=0..COLUMN_SIZE-1) SHALL write in_data into row_out bits [k*DATA_SIZE +: DATA_SIZE].
REQ-020 Bits above COLUMN_SIZE*DATA_SIZE of row_out SHALL always be zero.
REQ-021 On transfer k=COLUMN_SIZE-1, the FSM SHALL move to EMIT; element counter wraps to 0.
REQ-022 EMIT (exactly one cycle): enable=1, in_ready=0; row_out stable and complete.
REQ-023 Latency: enable SHALL assert in the cycle immediately after the last element of a row is accepted.
REQ-024 In EMIT, dendFlag=1 iff row counter = ROW_SIZE-1; row counter increments.
REQ-025 EMIT -> FINISH if it was the last row, else -> FILL.
REQ-026 FINISH (one cycle): done=1, busy=1, in_ready=0; then -> IDLE.
REQ-027 enable, dendFlag, done SHALL be low in all states other than those stated.
REQ-028 in_valid=0 in FILL SHALL stall without changing counters or row_out.
REQ-029 start and in_valid high in the same IDLE cycle: no transfer in that cycle; the first transfer occurs no earlier than the next cycle.
REQ-030 row_out SHALL hold its last value between rows; partial overwrite during FILL is permitted.

Reset
REQ-031 reset=1 at a clock edge SHALL force IDLE, zero both counters and set row_out=0, enable=0, dendFlag=0, done=0, busy=0, in_ready=0.
REQ-032 Reset in any state, including mid-row, SHALL abort the load with no enable or done pulse; the next load starts only on a new start.
REQ-033 reset SHALL take priority over start and in_valid.

Configuration
REQ-034 Macro ROW_LOADER_REVERSE_EN defined: transfer k SHALL write bits [(COLUMN_SIZE-1-k)*DATA_SIZE +: DATA_SIZE], so the first element lands at the top of the used field.
REQ-035 Macro ROW_LOADER_REVERSE_EN undefined: packing SHALL be per REQ-019; timing is identical in both builds.

Verification
REQ-036 Defaults; start, then 256 back-to-back elements valued 0x0000..0x00FF -> 16 enable pulses, each 17 cycles apart; row 0 row_out[15:0]=0x0000, row 0 row_out[255:240]=0x000F; dendFlag only on the 16th pulse; done one cycle later; busy low after done.
REQ-037 in_valid toggled 1/0 every cycle over one row -> enable 32 cycles after FILL entry; row contents identical to the unstalled case.
REQ-038 reset asserted after 7 elements of row 3 -> all outputs 0 next cycle, no enable or done; new start plus 256 elements -> normal 16-row sequence.
REQ-039 start pulsed during FILL, EMIT and FINISH -> no effect on counters, row_out or pulse timing.
REQ-040 ROW_LOADER_REVERSE_EN defined, row of elements 0xA000..0xA00F -> row_out[255:240]=0xA000, row_out[15:0]=0xA00F, row_out[1023:256]=0.

Source files
------------

// File: rtl/matrix_row_loader_if.sv
// ============================================================================
//  Module      : matrix_row_loader_if
//  Description : Bundle of the row loader's handshake and row bus signals.
//                The master side issues start and streams elements. The
//                slave side (the loader) returns ready, the packed row and
//                the status pulses.
//  Ports       : start, in_valid, in_data   - master -> loader
//                in_ready, row_out, enable,
//                dendFlag, busy, done       - loader -> master
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface matrix_row_loader_if #(
    parameter int DATA_SIZE = 16
) ();
    logic                 start;
    logic                 in_valid;
    logic [DATA_SIZE-1:0] in_data;
    logic                 in_ready;
    logic [1023:0]        row_out;
    logic                 enable;
    logic                 dendFlag;
    logic                 busy;
    logic                 done;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, row_out, enable, dendFlag, busy, done
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, row_out, enable, dendFlag, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/matrix_row_loader.sv
// ============================================================================
//  Module      : matrix_row_loader
//  Description : Collects a row-major element stream into packed rows for
//                the matrix core. After COLUMN_SIZE accepted elements the
//                completed row is announced by a one-cycle enable pulse.
//                dendFlag accompanies the pulse for the last of ROW_SIZE
//                rows. done pulses one cycle later.
//  Ports       : clock   - rising-edge clock
//                reset   - synchronous, active-high reset
//                bus     - matrix_row_loader_if.slave: start/in_valid/in_data
//                          in, in_ready/row_out/enable/dendFlag/busy/done out
//  Config      : ROW_LOADER_REVERSE_EN - when defined, element k is packed
//                into slot COLUMN_SIZE-1-k, so the first element lands at
//                the top of the used field. Timing is unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_row_loader #(
    parameter int DATA_SIZE   = 16,
    parameter int COLUMN_SIZE = 16,
    parameter int ROW_SIZE    = 16
) (
    input  wire logic             clock,
    input  wire logic             reset,
    matrix_row_loader_if.slave    bus
);

    localparam int c_FIELD_W = DATA_SIZE * COLUMN_SIZE;
    localparam int c_EW      = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;
    localparam int c_RW      = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        EMIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [c_EW-1:0]        r_elem_cnt;
    logic [c_RW-1:0]        r_row_cnt;
    logic [c_FIELD_W-1:0]   r_field;

    logic                   w_xfer;
    logic                   w_last_elem;
    logic                   w_last_row;
    logic [c_EW-1:0]        w_slot;
    logic                   w_in_ready;
    logic                   w_enable;
    logic                   w_dend;
    logic                   w_busy;
    logic                   w_done;

    assign w_xfer      = (r_state == FILL) && bus.in_valid;
    assign w_last_elem = (r_elem_cnt == c_EW'(COLUMN_SIZE - 1));
    assign w_last_row  = (r_row_cnt == c_RW'(ROW_SIZE - 1));

`ifdef ROW_LOADER_REVERSE_EN
    assign w_slot = c_EW'(COLUMN_SIZE - 1) - r_elem_cnt;
`else
    assign w_slot = r_elem_cnt;
`endif

    // Next state and state-decoded outputs
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_enable   = 1'b0;
        w_dend     = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = FILL;
                end
            end
            FILL: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (w_xfer && w_last_elem) begin
                    w_next = EMIT;
                end
            end
            EMIT: begin
                w_enable = 1'b1;
                w_busy   = 1'b1;
                // The row counter still holds the index of the row being
                // emitted; it advances at the end of this cycle.
                w_dend   = w_last_row;
                w_next   = w_last_row ? FINISH : FILL;
            end
            FINISH: begin
                w_done = 1'b1;
                w_busy = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_elem_cnt <= '0;
            r_row_cnt  <= '0;
            r_field    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_elem_cnt <= '0;
                        r_row_cnt  <= '0;
                    end
                end
                FILL: begin
                    if (w_xfer) begin
                        // Only the addressed slot changes; the rest of the
                        // previous row stays visible until overwritten.
                        for (int c = 0; c < COLUMN_SIZE; c++) begin
                            if (w_slot == c_EW'(c)) begin
                                r_field[c*DATA_SIZE +: DATA_SIZE] <= bus.in_data;
                            end
                        end
                        r_elem_cnt <= w_last_elem ? '0 : r_elem_cnt + 1'b1;
                    end
                end
                EMIT: begin
                    r_row_cnt <= r_row_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Bits above the used field are tied to zero.
    generate
        if (c_FIELD_W < 1024) begin : g_pad
            assign bus.row_out = {{(1024 - c_FIELD_W){1'b0}}, r_field};
        end else begin : g_full
            assign bus.row_out = r_field[1023:0];
        end
    endgenerate

    assign bus.in_ready = w_in_ready;
    assign bus.enable   = w_enable;
    assign bus.dendFlag = w_dend;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;

endmodule

`default_nettype wire

// File: tb/tb_matrix_row_loader.sv
// ============================================================================
//  Module      : tb_matrix_row_loader
//  Description : Self-checking bench for matrix_row_loader. A transaction
//                level model (element count since start, pending emit /
//                finish) predicts every output each cycle. Directed loads
//                pin the timing and packing with literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_row_loader;

    localparam int DW   = 16;
    localparam int COLS = 16;
    localparam int ROWS = 16;
`ifdef ROW_LOADER_REVERSE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    matrix_row_loader_if #(.DATA_SIZE(DW)) bus ();

    matrix_row_loader #(
        .DATA_SIZE   (DW),
        .COLUMN_SIZE (COLS),
        .ROW_SIZE    (ROWS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int start_cyc = 0;
    bit toggle   = 1'b0;

    // Model state
    bit            m_busy   = 1'b0;
    bit            m_emit   = 1'b0;
    bit            m_finish = 1'b0;
    int            m_taken  = 0;
    logic [DW-1:0] m_elem [COLS];

    logic [DW-1:0] src_q [$];
    int            en_q  [$];
    logic [1023:0] rows_q[$];
    bit            dq    [$];
    int            done_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_row(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        for (int q = 0; q < 4; q++) begin
            chk($sformatf("%s[%0d]", name, q), act[q*256 +: 256], exp[q*256 +: 256]);
        end
    endtask

    function automatic int slot_of(input int k);
        return REV ? (COLS - 1 - k) : k;
    endfunction

    function automatic logic [1023:0] model_row();
        logic [1023:0] r = '0;
        for (int c = 0; c < COLS; c++) r[slot_of(c)*DW +: DW] = m_elem[c];
        return r;
    endfunction

    function automatic logic [1023:0] seq_row(input int base);
        logic [1023:0] r = '0;
        for (int c = 0; c < COLS; c++) r[slot_of(c)*DW +: DW] = DW'(base + c);
        return r;
    endfunction

    // Transaction-level model, advanced on each rising edge
    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            m_busy = 0; m_emit = 0; m_finish = 0; m_taken = 0;
            for (int i = 0; i < COLS; i++) m_elem[i] = '0;
        end else if (!m_busy) begin
            if (bus.start) begin
                m_busy  = 1;
                m_taken = 0;
            end
        end else if (m_emit) begin
            m_emit = 0;
            if (m_taken == COLS * ROWS) m_finish = 1;
        end else if (m_finish) begin
            m_finish = 0;
            m_busy   = 0;
        end else if (bus.in_valid) begin
            m_elem[m_taken % COLS] = bus.in_data;
            m_taken++;
            if (src_q.size() > 0) void'(src_q.pop_front());
            if (m_taken % COLS == 0) m_emit = 1;
        end
    end

    // Element source
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        forever begin
            @(posedge clock);
            #2;
            bus.in_valid = (src_q.size() > 0) && (!toggle || ((cyc - start_cyc) % 2 == 0));
            bus.in_data  = (src_q.size() > 0) ? src_q[0] : '0;
        end
    end

    // Per-cycle compare against the model, plus event logging
    always @(negedge clock) begin
        chk("in_ready", 256'(bus.in_ready), 256'(m_busy && !m_emit && !m_finish));
        chk("enable",   256'(bus.enable),   256'(m_emit));
        chk("dendFlag", 256'(bus.dendFlag), 256'(m_emit && (m_taken == COLS * ROWS)));
        chk("done",     256'(bus.done),     256'(m_finish));
        chk("busy",     256'(bus.busy),     256'(m_busy));
        chk_row("row_out", bus.row_out, model_row());
        if (bus.enable === 1'b1) begin
            en_q.push_back(cyc);
            rows_q.push_back(bus.row_out);
            dq.push_back(bus.dendFlag === 1'b1);
        end
        if (bus.done === 1'b1) done_q.push_back(cyc);
    end

    task automatic clear_logs();
        en_q.delete(); rows_q.delete(); dq.delete(); done_q.delete();
    endtask

    task automatic load(input int base, input int n);
        for (int i = 0; i < n; i++) src_q.push_back(DW'(base + i));
    endtask

    task automatic do_start();
        @(posedge clock); #1;
        bus.start = 1'b1;
        start_cyc = cyc;
        @(posedge clock); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (done_q.size() == 0 && k < limit) begin
            @(posedge clock);
            k++;
        end
        chk("done_seen", 256'(done_q.size() > 0), 256'(1));
        repeat (2) @(posedge clock);
    endtask

    task automatic check_sequence(input int first_lat, input bit spaced);
        int bad = 0;
        int nd  = 0;
        chk("enable_count", 256'(en_q.size()), 256'(16));
        if (en_q.size() > 0) chk("first_latency", 256'(en_q[0] - start_cyc), 256'(first_lat));
        if (spaced) begin
            for (int i = 1; i < en_q.size(); i++) if (en_q[i] - en_q[i-1] != 17) bad++;
            chk("enable_spacing_errs", 256'(bad), 256'(0));
        end
        foreach (dq[i]) if (dq[i]) nd++;
        chk("dend_count", 256'(nd), 256'(1));
        if (dq.size() == 16) chk("dend_on_last", 256'(dq[15]), 256'(1));
        chk("done_count", 256'(done_q.size()), 256'(1));
        if (done_q.size() > 0 && en_q.size() > 0)
            chk("done_after_last", 256'(done_q[0] - en_q[en_q.size()-1]), 256'(1));
    endtask

    initial begin
        bus.start = 1'b0;
        reset     = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state, pinned literally
        @(negedge clock);
        chk("rst_row_out_lo", bus.row_out[255:0], 256'(0));
        chk("rst_busy",       256'(bus.busy),     256'(0));
        chk("rst_in_ready",   256'(bus.in_ready), 256'(0));

        // Back-to-back load 0x0000..0x00FF, in_valid already high with start
        clear_logs();
        load(0, 256);
        do_start();
        wait_done(400);
        check_sequence(17, 1'b1);
        if (rows_q.size() > 0) begin
            chk("row0_lo16", 256'(rows_q[0][15:0]),    REV ? 256'h000F : 256'h0000);
            chk("row0_hi16", 256'(rows_q[0][255:240]), REV ? 256'h0000 : 256'h000F);
            chk_row("row0", rows_q[0], seq_row(0));
        end
        if (rows_q.size() == 16) chk_row("row15", rows_q[15], seq_row(240));
        @(negedge clock);
        chk("busy_after_done", 256'(bus.busy), 256'(0));

        // in_valid toggling 0/1 from FILL entry
        clear_logs();
        load(16'h0100, 256);
        toggle = 1'b1;
        do_start();
        wait_done(800);
        toggle = 1'b0;
        check_sequence(33, 1'b0);
        if (rows_q.size() > 0) begin
            chk("stall_row0_lo16", 256'(rows_q[0][15:0]), REV ? 256'h010F : 256'h0100);
            chk_row("stall_row0", rows_q[0], seq_row(16'h0100));
        end

        // Reset after 7 elements of row 3
        clear_logs();
        load(0, 256);
        do_start();
        begin
            int k = 0;
            while (m_taken < 3 * COLS + 7 && k < 300) begin
                @(posedge clock); #1;
                k++;
            end
        end
        chk("enables_before_reset", 256'(en_q.size()), 256'(3));
        reset = 1'b1;
        src_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("abort_row_out_lo", bus.row_out[255:0], 256'(0));
        chk("abort_enable",     256'(bus.enable),   256'(0));
        chk("abort_busy",       256'(bus.busy),     256'(0));
        chk("abort_in_ready",   256'(bus.in_ready), 256'(0));
        repeat (40) @(posedge clock);
        chk("no_enable_after_abort", 256'(en_q.size()),   256'(3));
        chk("no_done_after_abort",   256'(done_q.size()), 256'(0));
        clear_logs();
        load(0, 256);
        do_start();
        wait_done(400);
        check_sequence(17, 1'b1);

        // start held high through FILL, EMIT and FINISH
        clear_logs();
        load(16'h0200, 256);
        @(posedge clock); #1;
        bus.start = 1'b1;
        start_cyc = cyc;
        begin
            int k = 0;
            do begin
                @(posedge clock); #1;
                k++;
            end while (m_busy && k < 400);
        end
        bus.start = 1'b0;
        repeat (3) @(posedge clock);
        check_sequence(17, 1'b1);
        if (rows_q.size() > 0) chk_row("noise_row0", rows_q[0], seq_row(16'h0200));
        @(negedge clock);
        chk("noise_idle_busy", 256'(bus.busy), 256'(0));

        // Packing check with 0xA000..0xA00F as row 0
        clear_logs();
        load(16'hA000, 16);
        load(0, 240);
        do_start();
        wait_done(400);
        if (rows_q.size() > 0) begin
            chk("pack_hi16",  256'(rows_q[0][255:240]), REV ? 256'hA000 : 256'hA00F);
            chk("pack_lo16",  256'(rows_q[0][15:0]),    REV ? 256'hA00F : 256'hA000);
            chk("pack_upper", 256'(rows_q[0][1023:256] != '0), 256'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
